// File: rtl/register_file_pkg.sv
// Shared register-index constants and small helpers for the tiny16 register file.
// The instruction sequencer imports the same indices.
package register_file_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned NUM_REGS = 16;

  localparam logic [IDX_W-1:0] REG_ZERO = 4'd0;
  localparam logic [IDX_W-1:0] REG_PC   = 4'd1;
  localparam logic [IDX_W-1:0] REG_SP   = 4'd2;
  localparam logic [IDX_W-1:0] REG_BA   = 4'd3;
  localparam logic [IDX_W-1:0] REG_RA   = 4'd4;
  localparam logic [IDX_W-1:0] REG_RES  = 4'd15;

  // Next stack pointer; inc and dec together cancel out.
  function automatic logic [DATA_W-1:0] sp_step(input logic [DATA_W-1:0] sp,
                                                input logic inc,
                                                input logic dec);
    logic [DATA_W-1:0] nxt;
    nxt = sp;
    if (inc && !dec) nxt = sp + 16'd1;
    if (dec && !inc) nxt = sp - 16'd1;
    return nxt;
  endfunction

  // Explicit (bus or byte) write result; in_en wins over the byte strobes.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] bus,
                                                   input logic in_en,
                                                   input logic lo_en,
                                                   input logic up_en);
    logic [DATA_W-1:0] nxt;
    nxt = old;
    if (in_en) begin
      nxt = bus;
    end else begin
      if (lo_en) nxt[7:0]  = bus[7:0];
      if (up_en) nxt[15:8] = bus[7:0];
    end
    return nxt;
  endfunction

endpackage

// File: rtl/register_file.sv
// tiny16 16x16 register file: executes sequencer strobes, drives the wired-OR bus
// and the ALU operands. Optional debug peek port under `REGFILE_DBG_EN`.
module register_file
  import register_file_pkg::*;
#(
  parameter logic [15:0] PC_INIT = 16'h0000,
  parameter logic [15:0] SP_INIT = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [15:0] in_i,
  input  logic [3:0]  reg_src_sel_i,
  input  logic [3:0]  reg_dst_sel_i,
  input  logic        reg_in_en_i,
  input  logic        reg_lo_en_i,
  input  logic        reg_up_en_i,
  input  logic        reg_pc_inc_i,
  input  logic        reg_sp_inc_i,
  input  logic        reg_sp_dec_i,
  input  logic        reg_out_en_i,
`ifdef REGFILE_DBG_EN
  input  logic [3:0]  dbg_sel_i,
  output logic [15:0] dbg_data_o,
`endif
  output logic [15:0] out_o,
  output logic [15:0] src_data_o,
  output logic [15:0] dst_data_o,
  output logic [15:0] pc_o,
  output logic [15:0] sp_o
);

  // ZERO is not stored; entries 1..15 only.
  logic [15:0] regs_q [1:15];
  logic [15:0] regs_d [1:15];
  logic [15:0] rd_view [NUM_REGS];
  logic        wr_any;

  assign wr_any = reg_in_en_i | reg_lo_en_i | reg_up_en_i;

  always_comb begin
    for (int i = 1; i < 16; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_any && (reg_dst_sel_i == 4'(i))) begin
        regs_d[i] = byte_merge(regs_q[i], in_i, reg_in_en_i, reg_lo_en_i, reg_up_en_i);
      end else if (4'(i) == REG_PC) begin
        regs_d[i] = reg_pc_inc_i ? regs_q[i] + 16'd1 : regs_q[i];
      end else if (4'(i) == REG_SP) begin
        regs_d[i] = sp_step(regs_q[i], reg_sp_inc_i, reg_sp_dec_i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 1; i < 16; i++) begin
        if (4'(i) == REG_PC)      regs_q[i] <= PC_INIT;
        else if (4'(i) == REG_SP) regs_q[i] <= SP_INIT;
        else                      regs_q[i] <= 16'h0000;
      end
    end else begin
      for (int i = 1; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    rd_view[0] = 16'h0000;
    for (int i = 1; i < 16; i++) begin
      rd_view[i] = regs_q[i];
    end
  end

  assign src_data_o = rd_view[reg_src_sel_i];
  assign dst_data_o = rd_view[reg_dst_sel_i];
  assign out_o      = reg_out_en_i ? rd_view[reg_src_sel_i] : 16'h0000;
  assign pc_o       = regs_q[REG_PC];
  assign sp_o       = regs_q[REG_SP];

`ifdef REGFILE_DBG_EN
  assign dbg_data_o = rd_view[dbg_sel_i];
`endif

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 16 x 16-bit register file for the tiny16 core. Sits directly downstream of the instruction sequencer and executes its register strobes: bus writes, byte loads (LLI/LUI), PC increment, and SP increment/decrement.
- Drives the shared bus on request.
- Feeds the ALU operand inputs continuously.
- Owns the architectural PC, SP, BA, RA and RES registers.

Parameters:
- PC_INIT, 16'h0000, PC value after reset.
- SP_INIT, 16'h0000, SP value after reset. The first PUSH pre-decrements SP, so it lands at 16'hFFFF.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset: synchronous, active-low.
- in  input  16  shared bus value (memory, ALU or control immediate).
- reg_src_sel  input  4  source register index.
- reg_dst_sel  input  4  destination register index.
- reg_in_en  input  1  write in[15:0] to reg[dst].
- reg_lo_en  input  1  write in[7:0] to reg[dst][7:0].
- reg_up_en  input  1  write in[7:0] to reg[dst][15:8].
- reg_pc_inc  input  1  PC <= PC + 1.
- reg_sp_inc  input  1  SP <= SP + 1.
- reg_sp_dec  input  1  SP <= SP - 1.
- reg_out_en  input  1  drive reg[src] onto out.
- out  output  16  reg[src] when reg_out_en=1, else 16'h0000 (wired-OR bus).
- src_data  output  16  reg[src], always valid (ALU operand B).
- dst_data  output  16  reg[dst], always valid (ALU operand A).
- pc  output  16  current PC.
- sp  output  16  current SP.

Behaviour:
- Register map:
  - 0 = ZERO: reads 0, writes ignored.
  - 1 = PC, 2 = SP, 3 = BA, 4 = RA.
  - 5..14 = general purpose.
  - 15 = RES (immediate scratch).
- Reads are combinational. out, src_data and dst_data reflect register state before the coming posedge.
- Writes occur on posedge clk. Strobes arrive from the negedge-driven sequencer and are stable a half-cycle before the edge.
- Reset (rst=0 at posedge):
  - PC <= PC_INIT, SP <= SP_INIT, all other registers <= 0.
  - Reset overrides every strobe in the same cycle, including mid-instruction.
  - Outputs follow combinationally: out = 0, src_data/dst_data = reset contents.
- Write precedence for reg[dst], per cycle:
  - reg_in_en: full 16-bit write; lo/up strobes are ignored.
  - Otherwise reg_lo_en and reg_up_en apply independently. With both set, the register becomes {in[7:0], in[7:0]}.
  - Byte writes preserve the other byte.
- PC:
  - An explicit write (in/lo/up with dst=PC) takes precedence over reg_pc_inc in the same cycle.
  - Increment is modulo 2^16 (16'hFFFF -> 16'h0000).
- SP:
  - An explicit write with dst=SP takes precedence over inc/dec.
  - inc and dec together: SP unchanged.
  - Arithmetic is modulo 2^16 in both directions.
- Strobes to different registers in the same cycle all take effect. Example: reg_pc_inc together with reg_in_en to R5.
- Source equal to destination: reads return the old value; the new value is visible after the edge.
- No internal state machine beyond the registers.

Optional Feature:
- Macro: REGFILE_DBG_EN.
- Defined: adds input dbg_sel[3:0] and output dbg_data[15:0]. dbg_data = reg[dbg_sel], combinational and independent of all strobes (testbench/display peek).
- Undefined: both ports absent; no logic generated.

Decomposition:
- Shared package holds the register index constants ZERO=0, PC=1, SP=2, BA=3, RA=4, RES=15. The sequencer uses the same constants.
- No sub-module needed: single flat module with a 15-entry array (ZERO not stored) plus a write-enable decode.

Test Plan:
- Reset: rst=0 for one posedge with reg_in_en=1, dst=5, in=16'hAAAA -> pc=0x0000, sp=0x0000, R5=0x0000, out=0.
- LLI/LUI: dst=7, in=0x0034 with lo_en, next cycle in=0x0012 with up_en -> dst_data=0x1234. Then lo_en+up_en with in=0x00AB -> 0xABAB.
- PC collision: pc=0x0010, reg_pc_inc=1, reg_in_en=1, dst=PC, in=0x0200 -> pc=0x0200. Inc alone at 0xFFFF -> 0x0000.
- SP: from reset, sp_dec -> 0xFFFF; sp_inc -> 0x0000; inc+dec together -> unchanged; reg_in_en dst=SP in=0x8000 with sp_dec -> 0x8000.
- ZERO/bus gating: reg_in_en dst=0 in=0xBEEF -> src_data(sel 0)=0. R5=0x1234 with src=5 and reg_out_en=0 -> out=0; reg_out_en=1 -> out=0x1234.
- Same-cycle independence: reg_pc_inc=1 and reg_in_en dst=5 in=0x0042 -> PC+1 and R5=0x0042 after one edge.
